instr_fetch: RTL

Instruction fetch controller for the single-cycle core: it holds the architectural PC and feeds it to the PC-update logic. It accepts that logic's `nextpc`/`pc_updated` result, fetches each instruction from instruction memory over a request/grant/valid interface, and presents it to decode with a valid/ready handshake. It is the consumer end of the `nextpc`/`pc_updated` interface, and the producer of `pc` toward the updater.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/instr_fetch.sv | 105 ++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: FSM state encoding
// and default sizing constants.
package fetch_pkg;

    localparam int unsigned DEF_XLEN     = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        DELIVER    = 2'd2,
        WAIT_PC    = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch controller: requests the word at pc, waits for read data,
// hands it to decode, then waits for the PC-update logic to supply the next pc.
//
// state      | meaning
// FETCH_REQ  | imem_req high with imem_addr = pc, waiting for imem_gnt
// FETCH_WAIT | request granted, waiting for imem_rvalid
// DELIVER    | instr_valid high, waiting for instr_ready
// WAIT_PC    | instruction consumed, waiting for pc_updated
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned      XLEN     = DEF_XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEF_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] nextpc,
    input  logic            pc_updated,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    output logic [31:0]     fetch_count
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic [31:0]     fetch_count_q;
    wire  [31:0]     fetch_count_d;
    logic            handshake;

    assign handshake     = (state_q == DELIVER) && instr_ready;
    assign fetch_count_d = handshake ? fetch_count_q + 32'd1 : fetch_count_q;

    // pc_updated only matters in WAIT_PC or the DELIVER handshake cycle, since
    // the updater is allowed to pulse it every cycle.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        case (state_q)
            FETCH_REQ: begin
                if (imem_gnt) state_d = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (imem_rvalid) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    state_d    = DELIVER;
                end
            end
            DELIVER: begin
                if (instr_ready) begin
                    if (pc_updated) begin
                        pc_d    = nextpc;
                        state_d = FETCH_REQ;
                    end else begin
                        state_d = WAIT_PC;
                    end
                end
            end
            WAIT_PC: begin
                if (pc_updated) begin
                    pc_d    = nextpc;
                    state_d = FETCH_REQ;
                end
            end
            default: state_d = FETCH_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FETCH_REQ;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign pc          = pc_q;
    assign imem_req    = (state_q == FETCH_REQ);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == DELIVER);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign fetch_count = fetch_count_q;

endmodule
